hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage MIPS core. It generates the stall and flush controls for the IF/ID register, the ID/EX and EX/MEM registers and the PC. It detects load-use hazards and taken branches/jumps resolved in ID, sequences the multi-cycle multiply/divide unit, and performs precise-exception flushing. It also keeps a saturating stall-cycle counter for performance measurement.

---
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use/MD stalls, branch and exception flushes
// Stall and flush controls are combinational from the registered state; the state tracks MD progress and the post-trap slot.
module hazard_ctrl #(
    parameter int MD_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  ID_rs,
    input  logic [4:0]  ID_rt,
    input  logic        ID_uses_rt,
    input  logic        ID_md_read,
    input  logic        ID_branch_taken,
    input  logic        ID_jump,
    input  logic        EX_MemRead,
    input  logic [4:0]  EX_rt,
    input  logic        EX_md_start,
    input  logic        EX_exception,
    output logic        stall,
    output logic        PC_write,
    output logic        IFID_flush,
    output logic        IDEX_flush,
    output logic        EXMEM_flush,
    output logic        md_busy,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MD_WAIT   = 2'd1,
        EXC_FLUSH = 2'd2
    } state_t;

    localparam logic [4:0] MD_LOAD = 5'(MD_CYCLES - 1);

    state_t     state;
    logic [4:0] md_cnt;
    logic       load_use;
    logic       md_hazard;
    logic       trap;

    assign md_busy   = (state == MD_WAIT);
    assign load_use  = EX_MemRead && (EX_rt != 5'd0) &&
                       ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
    assign md_hazard = ID_md_read && md_busy;
    // The slot right after a trap is already squashed, so its exception flag is ignored.
    assign trap      = EX_exception && (state != EXC_FLUSH);

    always_comb begin
        stall       = 1'b0;
        PC_write    = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        if (!reset) begin
            if (trap) begin
                IFID_flush  = 1'b1;
                IDEX_flush  = 1'b1;
                EXMEM_flush = 1'b1;
                PC_write    = 1'b1;
            end else if (load_use || md_hazard) begin
                // Stall dominates: a taken branch is re-evaluated once the stall clears.
                stall      = 1'b1;
                IDEX_flush = 1'b1;
            end else if (ID_branch_taken || ID_jump) begin
                IFID_flush = 1'b1;
                PC_write   = 1'b1;
            end else begin
                PC_write = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            md_cnt      <= 5'd0;
            stall_count <= 16'd0;
        end else begin
            if (stall && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;

            if (trap) begin
                state  <= EXC_FLUSH;
                md_cnt <= 5'd0;
            end else begin
                case (state)
                    RUN: begin
                        if (EX_md_start) begin
                            state  <= MD_WAIT;
                            md_cnt <= MD_LOAD;
                        end
                    end
                    MD_WAIT: begin
                        if (md_cnt == 5'd1) begin
                            state  <= RUN;
                            md_cnt <= 5'd0;
                        end else begin
                            md_cnt <= md_cnt - 5'd1;
                        end
                    end
                    EXC_FLUSH: state <= RUN;
                    default:   state <= RUN;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl against a cycle-window reference model
module tb_hazard_ctrl;

    localparam int MD_CYCLES = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  ID_rs, ID_rt, EX_rt;
    logic        ID_uses_rt, ID_md_read, ID_branch_taken, ID_jump;
    logic        EX_MemRead, EX_md_start, EX_exception;
    logic        stall, PC_write, IFID_flush, IDEX_flush, EXMEM_flush, md_busy;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    // Model state: MD busy window [md_lo, md_hi] in absolute cycles, cycle of the last trap, stall total.
    int cyc, md_lo, md_hi, exc_cyc, m_count;
    bit e_stall, e_pc, e_ifid, e_idex, e_exmem, e_busy;

    hazard_ctrl #(.MD_CYCLES(MD_CYCLES)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt), .ID_md_read(ID_md_read),
        .ID_branch_taken(ID_branch_taken), .ID_jump(ID_jump),
        .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .EX_md_start(EX_md_start),
        .EX_exception(EX_exception),
        .stall(stall), .PC_write(PC_write), .IFID_flush(IFID_flush),
        .IDEX_flush(IDEX_flush), .EXMEM_flush(EXMEM_flush), .md_busy(md_busy),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic clear_inputs();
        reset = 1'b0; ID_rs = 5'd0; ID_rt = 5'd0; EX_rt = 5'd0;
        ID_uses_rt = 1'b0; ID_md_read = 1'b0; ID_branch_taken = 1'b0; ID_jump = 1'b0;
        EX_MemRead = 1'b0; EX_md_start = 1'b0; EX_exception = 1'b0;
    endtask

    task automatic model_reset();
        md_lo = 0; md_hi = -1; exc_cyc = -10; m_count = 0;
    endtask

    task automatic model_eval();
        bit lu, in_flush, trap;
        e_busy   = (cyc >= md_lo) && (cyc <= md_hi);
        in_flush = (cyc == exc_cyc + 1);
        lu = EX_MemRead && (EX_rt != 0) && ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
        trap = EX_exception && !in_flush;
        {e_stall, e_pc, e_ifid, e_idex, e_exmem} = 5'b0;
        if (reset) begin
            // all controls low
        end else if (trap) begin
            {e_pc, e_ifid, e_idex, e_exmem} = 4'b1111;
        end else if (lu || (ID_md_read && e_busy)) begin
            e_stall = 1; e_idex = 1;
        end else begin
            e_pc   = 1;
            e_ifid = ID_branch_taken || ID_jump;
        end
    endtask

    task automatic model_advance();
        bit in_flush, trap;
        in_flush = (cyc == exc_cyc + 1);
        trap = EX_exception && !in_flush;
        if (reset) begin
            model_reset();
        end else begin
            if (e_stall && m_count < 65535) m_count++;
            if (trap) begin
                exc_cyc = cyc;
                md_hi = cyc;
            end else if (!e_busy && !in_flush && EX_md_start) begin
                md_lo = cyc + 1;
                md_hi = cyc + MD_CYCLES - 1;
            end
        end
        cyc++;
    endtask

    // Inputs are applied just after a negedge; outputs are compared mid-cycle, state advances at posedge.
    task automatic step(input bit do_check);
        #1;
        model_eval();
        if (do_check) begin
            check("stall", stall, e_stall);
            check("PC_write", PC_write, e_pc);
            check("IFID_flush", IFID_flush, e_ifid);
            check("IDEX_flush", IDEX_flush, e_idex);
            check("EXMEM_flush", EXMEM_flush, e_exmem);
            check("md_busy", md_busy, e_busy);
            check("stall_count", stall_count, m_count);
        end
        @(posedge clk);
        model_advance();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        step(1'b1);
        step(1'b1);
        reset = 1'b0;
    endtask

    initial begin
        int n_busy, n_stall;
        cyc = 0;
        model_reset();
        clear_inputs();
        reset = 1'b1;
        @(negedge clk);
        do_reset();
        check("reset_count", stall_count, 0);

        // Load-use on rs: one stall cycle, then normal flow.
        EX_MemRead = 1; EX_rt = 5'd5; ID_rs = 5'd5;
        #1 check("lu_stall", stall, 1);
        check("lu_pcw", PC_write, 0);
        step(1'b1);
        EX_MemRead = 0;
        #1 check("lu_after", stall, 0);
        step(1'b1);
        // Load to $zero never stalls.
        EX_MemRead = 1; EX_rt = 5'd0; ID_rs = 5'd0;
        #1 check("lu_r0", stall, 0);
        step(1'b1);
        clear_inputs();

        // Taken branch alone, then with a load-use.
        ID_branch_taken = 1;
        #1 check("br_flush", IFID_flush, 1);
        step(1'b1);
        EX_MemRead = 1; EX_rt = 5'd7; ID_rt = 5'd7; ID_uses_rt = 1;
        #1 check("br_lu_flush", IFID_flush, 0);
        check("br_lu_stall", stall, 1);
        step(1'b1);
        clear_inputs();

        // MD sequence: busy and stall for MD_CYCLES-1 cycles.
        do_reset();
        EX_md_start = 1;
        step(1'b1);
        EX_md_start = 0; ID_md_read = 1;
        n_busy = 0; n_stall = 0;
        for (int i = 0; i < MD_CYCLES + 2; i++) begin
            #1;
            if (md_busy) n_busy++;
            if (stall) n_stall++;
            step(1'b1);
        end
        check("md_busy_len", n_busy, MD_CYCLES - 1);
        check("md_stall_len", n_stall, MD_CYCLES - 1);
        check("md_count", stall_count, MD_CYCLES - 1);
        clear_inputs();

        // Exception in the third MD_WAIT cycle, held high into the flush slot.
        do_reset();
        EX_md_start = 1;
        step(1'b1);
        EX_md_start = 0;
        step(1'b1);
        step(1'b1);
        EX_exception = 1;
        #1 check("exc_exmem", EXMEM_flush, 1);
        check("exc_pcw", PC_write, 1);
        step(1'b1);
        #1 check("exc_busy_drop", md_busy, 0);
        check("exc_masked", EXMEM_flush, 0);
        step(1'b1);
        #1 check("exc_retrap", EXMEM_flush, 1);
        step(1'b1);
        clear_inputs();

        // Reset in the middle of an MD op with 100 stalls accumulated.
        do_reset();
        EX_MemRead = 1; EX_rt = 5'd3; ID_rs = 5'd3;
        for (int i = 0; i < 100; i++) step(1'b0);
        check("pre_count", stall_count, 100);
        clear_inputs();
        EX_md_start = 1;
        step(1'b1);
        EX_md_start = 0;
        step(1'b1);
        reset = 1;
        #1 check("rst_pcw", PC_write, 0);
        step(1'b1);
        #1 check("rst_busy", md_busy, 0);
        check("rst_count", stall_count, 0);
        step(1'b1);
        clear_inputs();
        step(1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            reset           = ($urandom_range(0, 99) == 0);
            ID_rs           = 5'($urandom_range(0, 3));
            ID_rt           = 5'($urandom_range(0, 3));
            EX_rt           = 5'($urandom_range(0, 3));
            ID_uses_rt      = 1'($urandom);
            ID_md_read      = 1'($urandom);
            ID_branch_taken = ($urandom_range(0, 3) == 0);
            ID_jump         = ($urandom_range(0, 5) == 0);
            EX_MemRead      = ($urandom_range(0, 2) == 0);
            EX_md_start     = ($urandom_range(0, 5) == 0);
            EX_exception    = ($urandom_range(0, 15) == 0);
            step(1'b1);
        end

        // Saturation of the stall counter.
        do_reset();
        EX_MemRead = 1; EX_rt = 5'd9; ID_rs = 5'd9;
        for (int i = 0; i < 65540; i++) step(1'b0);
        #1 check("sat_count", stall_count, 16'hFFFF);
        step(1'b1);
        #1 check("sat_hold", stall_count, 16'hFFFF);
        clear_inputs();
        step(1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
